// File: rtl/riscv.sv
// Shared RV32I decode definitions: opcodes, instruction classes, the per-lane
// decode record and immediate generation.
// Optional macro INSN_DECODE_TRACE_EN adds the raw instruction word to the
// decode record so the stage can print it when a bundle leaves.
package riscv;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // ILLEGAL is encoded as zero so an all-zero record reads as "nothing here".
    typedef enum logic [3:0] {
        CLS_ILLEGAL  = 4'd0,
        CLS_LUI      = 4'd1,
        CLS_AUIPC    = 4'd2,
        CLS_JAL      = 4'd3,
        CLS_JALR     = 4'd4,
        CLS_BRANCH   = 4'd5,
        CLS_LOAD     = 4'd6,
        CLS_STORE    = 4'd7,
        CLS_OP_IMM   = 4'd8,
        CLS_OP       = 4'd9,
        CLS_MISC_MEM = 4'd10,
        CLS_SYSTEM   = 4'd11
    } insn_class_e;

    typedef struct packed {
`ifdef INSN_DECODE_TRACE_EN
        logic [31:0] insn;
`endif
        insn_class_e insn_class;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        illegal;
    } decode_info_t;

    // Occupancy of the stage: main register only, or main plus skid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    // Map a 7-bit opcode to its class; anything unlisted is ILLEGAL.
    function automatic insn_class_e opcode_class(input logic [6:0] opc);
        insn_class_e cls;
        case (opc)
            OPC_LUI:      cls = CLS_LUI;
            OPC_AUIPC:    cls = CLS_AUIPC;
            OPC_JAL:      cls = CLS_JAL;
            OPC_JALR:     cls = CLS_JALR;
            OPC_BRANCH:   cls = CLS_BRANCH;
            OPC_LOAD:     cls = CLS_LOAD;
            OPC_STORE:    cls = CLS_STORE;
            OPC_OP_IMM:   cls = CLS_OP_IMM;
            OPC_OP:       cls = CLS_OP;
            OPC_MISC_MEM: cls = CLS_MISC_MEM;
            OPC_SYSTEM:   cls = CLS_SYSTEM;
            default:      cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

    // Sign-extended immediate for the format implied by the class.
    // R-type (OP) and ILLEGAL carry no immediate and return zero.
    function automatic logic [31:0] imm_gen(input logic [31:0] insn, input insn_class_e cls);
        logic [31:0] imm;
        case (cls)
            CLS_LUI, CLS_AUIPC:
                imm = {insn[31:12], 12'b0};
            CLS_JAL:
                imm = {{12{insn[31]}}, insn[19:12], insn[20], insn[30:21], 1'b0};
            CLS_JALR, CLS_LOAD, CLS_OP_IMM, CLS_MISC_MEM, CLS_SYSTEM:
                imm = {{20{insn[31]}}, insn[31:20]};
            CLS_STORE:
                imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
            CLS_BRANCH:
                imm = {{20{insn[31]}}, insn[7], insn[30:25], insn[11:8], 1'b0};
            default:
                imm = 32'h0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/rv32_lane_decode.sv
// Combinational RV32I decode of a single instruction lane.
// With INSN_DECODE_TRACE_EN the raw word is copied into the record.
module rv32_lane_decode
    import riscv::*;
(
    input  logic         lane_valid,
    input  logic [31:0]  insn,
    output decode_info_t info
);

    insn_class_e opc_cls;
    logic        is_illegal;

    assign opc_cls    = opcode_class(insn[6:0]);
    assign is_illegal = (insn[1:0] != 2'b11) || (opc_cls == CLS_ILLEGAL);

    // Build the lane record; a masked-off lane yields an all-zero record.
    always_comb begin
        info = '0;
        if (lane_valid) begin
            info.insn_class = is_illegal ? CLS_ILLEGAL : opc_cls;
            info.rd         = insn[11:7];
            info.rs1        = insn[19:15];
            info.rs2        = insn[24:20];
            info.imm        = is_illegal ? 32'h0 : imm_gen(insn, opc_cls);
            info.illegal    = is_illegal;
`ifdef INSN_DECODE_TRACE_EN
            info.insn       = insn;
`endif
        end
    end

endmodule

// File: rtl/insn_decode_stage.sv
// Multi-lane RV32I decode stage between fetch and issue.
// Decodes a bundle of LANES instructions and registers the result behind a
// 2-entry (main + skid) buffer so in_ready never depends on out_ready
// combinationally. Optional macro INSN_DECODE_TRACE_EN prints every lane of
// each bundle as it leaves the stage.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready
// are both high; valid may not wait on ready, and while out_valid is high
// and out_ready is low every out_* signal holds its value.
module insn_decode_stage
    import riscv::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LANES      = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [LANES-1:0]                      in_lane_mask,
    input  logic [ADDR_WIDTH-3:0]                 in_pc,
    input  logic [LANES*32-1:0]                   in_insn,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [LANES-1:0]                      out_lane_mask,
    output logic [ADDR_WIDTH-3:0]                 out_pc,
    output logic [LANES*$bits(decode_info_t)-1:0] out_info,
    output logic                                  out_illegal_any
);

    localparam int IW = $bits(decode_info_t);
    localparam int PW = ADDR_WIDTH - 2;

    // ---------------- per-lane decode ----------------
    decode_info_t          lane_info [LANES];
    logic [LANES*IW-1:0]   dec_bus;
    logic [LANES-1:0]      lane_illegal;
    logic                  dec_illegal_any;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        rv32_lane_decode u_dec (
            .lane_valid (in_lane_mask[i]),
            .insn       (in_insn[32*i +: 32]),
            .info       (lane_info[i])
        );
        assign dec_bus[i*IW +: IW] = lane_info[i];
        assign lane_illegal[i]     = lane_info[i].illegal;
    end

    assign dec_illegal_any = |lane_illegal;

    // ---------------- occupancy state and storage ----------------
    stage_state_e          state_q, state_d;
    logic                  in_ready_q;

    logic [LANES-1:0]      main_mask_q;
    logic [PW-1:0]         main_pc_q;
    logic [LANES*IW-1:0]   main_info_q;
    logic                  main_ill_q;

    logic [LANES-1:0]      skid_mask_q;
    logic [PW-1:0]         skid_pc_q;
    logic [LANES*IW-1:0]   skid_info_q;
    logic                  skid_ill_q;

    logic                  in_fire;
    logic                  accept;
    logic                  out_fire;
    logic                  load_main_in;
    logic                  load_main_skid;
    logic                  load_skid;

    // An all-lanes-masked bundle completes the handshake but stores nothing.
    assign in_fire  = in_valid && in_ready_q;
    assign accept   = in_fire && (|in_lane_mask);
    assign out_fire = (state_q != ST_EMPTY) && out_ready;

    // Next occupancy and which register loads; flush overrides everything.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        load_main_in = 1'b1;
                        state_d      = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_d   = ST_FULL;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        load_main_skid = 1'b1;
                        state_d        = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Occupancy register; in_ready is precomputed from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    // Main register: drives the outputs, loads from input or from skid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_mask_q <= '0;
            main_pc_q   <= '0;
            main_info_q <= '0;
            main_ill_q  <= 1'b0;
        end else if (flush) begin
            main_mask_q <= '0;
            main_pc_q   <= '0;
            main_info_q <= '0;
            main_ill_q  <= 1'b0;
        end else if (load_main_in) begin
            main_mask_q <= in_lane_mask;
            main_pc_q   <= in_pc;
            main_info_q <= dec_bus;
            main_ill_q  <= dec_illegal_any;
        end else if (load_main_skid) begin
            main_mask_q <= skid_mask_q;
            main_pc_q   <= skid_pc_q;
            main_info_q <= skid_info_q;
            main_ill_q  <= skid_ill_q;
        end
    end

    // Skid register: holds the bundle accepted while the consumer stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_mask_q <= '0;
            skid_pc_q   <= '0;
            skid_info_q <= '0;
            skid_ill_q  <= 1'b0;
        end else if (load_skid) begin
            skid_mask_q <= in_lane_mask;
            skid_pc_q   <= in_pc;
            skid_info_q <= dec_bus;
            skid_ill_q  <= dec_illegal_any;
        end
    end

    assign in_ready        = in_ready_q;
    assign out_valid       = (state_q != ST_EMPTY);
    assign out_lane_mask   = main_mask_q;
    assign out_pc          = main_pc_q;
    assign out_info        = main_info_q;
    assign out_illegal_any = main_ill_q;

`ifdef INSN_DECODE_TRACE_EN
    for (genvar i = 0; i < LANES; i++) begin : g_trace
        decode_info_t trace_info;
        assign trace_info = main_info_q[i*IW +: IW];

        // Print this lane of each bundle as it leaves the stage.
        always_ff @(posedge clk) begin
            if (!rst && out_valid && out_ready && main_mask_q[i]) begin
                $display("%0t lane%0d pc=%h insn=%h %s rd=%0d rs1=%0d rs2=%0d imm=%h illegal=%0b",
                         $time, i, {main_pc_q + PW'(i), 2'b00}, trace_info.insn,
                         trace_info.insn_class.name(), trace_info.rd, trace_info.rs1,
                         trace_info.rs2, trace_info.imm, trace_info.illegal);
            end
        end
    end
`endif

endmodule

// File: doc/insn_decode_stage.md
Name: insn_decode_stage

Overview:
- Parametrised, multi-lane RV32I decode stage between fetch and issue in the mig-u core.
- Accepts a bundle of LANES instruction words plus a word-aligned PC over a valid/ready handshake.
- Decodes each lane into a per-lane info record and presents the result one cycle later on a registered valid/ready output.
- A 2-entry skid buffer keeps in_ready off the combinational path from out_ready; flush squashes all in-flight bundles.

Parameters:
ADDR_WIDTH, 32, byte-address width; PCs carried as word addresses [ADDR_WIDTH-1:2]
LANES, 2, instructions per bundle (1..4); lane i PC = in_pc + i (word units)

Ports:
clk  in  1  core clock
rst  in  1  reset, asynchronous, active-high
flush  in  1  squash all held bundles
in_valid  in  1  input bundle valid
in_ready  out  1  stage can accept (registered)
in_lane_mask  in  LANES  per-lane valid; lane 0 is oldest
in_pc  in  ADDR_WIDTH-2  word PC of lane 0
in_insn  in  LANES*32  lane i at [32*i+31:32*i]
out_valid  out  1  output bundle valid
out_ready  in  1  consumer accepts
out_lane_mask  out  LANES  registered copy of accepted mask
out_pc  out  ADDR_WIDTH-2  registered lane-0 word PC
out_info  out  LANES*$bits(decode_info_t)  per-lane decoded record
out_illegal_any  out  1  OR of illegal over valid lanes in output bundle

Behaviour:
- Clock and reset: one clock clk; reset rst is asynchronous and active-high.
- Reset values: out_valid=0, in_ready=1, out_lane_mask=0, out_pc=0, out_info=0, out_illegal_any=0, skid empty.
- Input fire: in_valid && in_ready. Output fire: out_valid && out_ready. Latency is 1 cycle from input fire to out_valid.
- Per-lane decode (combinational, before capture):
  - class ∈ {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, MISC_MEM, SYSTEM, ILLEGAL}, taken from opcode[6:0].
  - rd = insn[11:7], rs1 = insn[19:15], rs2 = insn[24:20].
  - Immediate per format I/S/B/U/J, sign-extended to 32 bits.
  - illegal = 1 when insn[1:0] != 2'b11 or the opcode is unlisted; class is then ILLEGAL.
  - Masked-off lanes decode to all-zero info.
- Storage: main register (drives outputs) plus skid register.
- State machine (implicit) with three states:
  - EMPTY: accept loads main -> ONE.
  - ONE:
    - accept with output fire -> main reloads, stays ONE.
    - accept without output fire -> skid loads -> FULL, in_ready=0 next cycle.
    - output fire without accept -> EMPTY.
  - FULL: in_ready=0; output fire -> skid moves to main -> ONE, in_ready=1 next cycle.
- Bundle with in_valid=1 and in_lane_mask=0: handshake completes, nothing stored, state unchanged.
- Flush has priority over everything: main and skid invalidated next edge, state -> EMPTY, in_ready=1 next cycle. An input fire in the flush cycle is discarded. An output fire in the flush cycle still counts as consumed.
- Output stability: while out_valid && !out_ready, all out_* signals hold stable.
- Reset asserted mid-operation clears state immediately (async); no bundle survives.

Optional Feature:
- Macro: INSN_DECODE_TRACE_EN.
- Defined: on every output fire, $display per valid lane: time, byte PC ({pc, 2'b00}), raw insn, class name, rd/rs1/rs2, imm, illegal. The raw insn is carried in the record only under this macro.
- Undefined: no display code and no raw-insn field; functional behaviour identical.

Decomposition:
- Package riscv (shared) holds:
  - opcode localparams;
  - enum insn_class_e;
  - struct decode_info_t {class, rd, rs1, rs2, imm[31:0], illegal};
  - function imm_gen.
- Sub-module rv32_lane_decode: purely combinational, one instance per lane via generate. The stage owns handshake and storage.

Test Plan:
- LANES=2, mask=2'b11, pc=0x100, insn0=0x00500093, insn1=0x12345137 -> next cycle out_valid=1, out_pc=0x100; lane0 OP_IMM rd=1 rs1=0 imm=5; lane1 LUI rd=2 imm=0x12345000; out_illegal_any=0.
- Lane0 0xFE208EE3 -> BRANCH rs1=1 rs2=2 imm=0xFFFFFFFC; lane1 0x00000000 with mask=2'b11 -> lane1 illegal, out_illegal_any=1.
- Hold out_ready=0, send 3 back-to-back bundles -> first two accepted, in_ready=0 from cycle 3; release out_ready -> bundles emerge in order, in_ready returns 1 one cycle after the skid drains.
- State FULL, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1; flushed input never appears.
- in_valid=1, mask=0 -> in_ready stays 1, out_valid stays 0.
- Assert rst mid-stream with FULL state -> outputs take reset values asynchronously, before the next clk edge.
